// File: rtl/ins_prefetch_queue_pkg.sv
// Shared types and defaults for the instruction prefetch queue.
package ins_prefetch_queue_pkg;

    localparam int unsigned PC_W   = 16;
    localparam int unsigned BYTE_W = 8;
    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 16'h0000;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0]   addr;
        logic [BYTE_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/ins_prefetch_queue_if.sv
// ROM-side and decoder-side signals of the prefetcher, plus FSM state for observation.
interface ins_prefetch_queue_if
    import ins_prefetch_queue_pkg::*;
#(
    parameter int unsigned ADDR_W = PC_W,
    parameter int unsigned DATA_W = BYTE_W
);
    // Decoder handshake: a byte moves on any posedge where ins_valid & ins_ready;
    // ins_valid never depends on ins_ready, and an offered byte stays stable until taken or flushed.
    logic              bus_busy;
    logic              flush;
    logic [ADDR_W-1:0] flush_pc;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_psen;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] ins_byte;
    logic [ADDR_W-1:0] ins_pc;
    logic              ins_valid;
    logic              ins_ready;
    fetch_state_e      dbg_state;

    modport master (
        input  bus_busy, flush, flush_pc, rom_data, ins_ready,
        output rom_addr, rom_psen, ins_byte, ins_pc, ins_valid, dbg_state
    );

    modport slave (
        output bus_busy, flush, flush_pc, rom_data, ins_ready,
        input  rom_addr, rom_psen, ins_byte, ins_pc, ins_valid, dbg_state
    );

endinterface

// File: rtl/ins_prefetch_queue_fifo.sv
// Register-based sync FIFO of tagged instruction bytes; the head is read straight from storage.
module ins_fifo
    import ins_prefetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  fifo_entry_t      wdata,
    output fifo_entry_t      rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    fifo_entry_t      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ins_prefetch_queue.sv
// Instruction-byte prefetcher: issues sequential ROM reads ahead of the decoder and redirects on flush.
module ins_prefetch_queue
    import ins_prefetch_queue_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       ADDR_W   = PC_W,
    parameter int unsigned       DATA_W   = BYTE_W,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                 clk,
    input  logic                 reset,
    ins_prefetch_queue_if.master bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] ret_addr_q, ret_addr_d;
    logic              inflight_q, inflight_d;
    logic              discard_q, discard_d;
    logic              issue;
    logic              rom_psen;
    logic [CNT_W:0]    credit_used;
    logic              credit_ok;

    logic              fifo_clear;
    logic              fifo_push;
    logic              fifo_pop;
    fifo_entry_t       fifo_wdata;
    fifo_entry_t       fifo_rdata;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    // Bytes already queued plus the one on the ROM bus must fit, so a return is never dropped for space.
    assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign credit_ok   = (credit_used < DEPTH_C);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        discard_d  = 1'b0;
        fifo_clear = 1'b0;
        issue      = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.flush) begin
                    fifo_clear = 1'b1;
                    fetch_pc_d = bus.flush_pc;
                    discard_d  = inflight_q;
                    state_d    = FLUSH;
                end else begin
                    issue = ~bus.bus_busy & credit_ok;
                    if (issue) begin
                        fetch_pc_d = fetch_pc_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (bus.flush) begin
                    fifo_clear = 1'b1;
                    fetch_pc_d = bus.flush_pc;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // No strobe while reset is held, even though the reset state would otherwise issue.
    assign rom_psen   = issue & ~reset;
    assign inflight_d = rom_psen;
    assign ret_addr_d = rom_psen ? fetch_pc_q : ret_addr_q;

    // A byte returning alongside a flush belongs to the abandoned stream.
    assign fifo_push  = inflight_q & ~discard_q & ~bus.flush & ~fifo_full;
    assign fifo_pop   = ~fifo_empty & bus.ins_ready & ~bus.flush;
    assign fifo_wdata = '{addr: ret_addr_q, data: bus.rom_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            ret_addr_q <= '0;
            inflight_q <= 1'b0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            ret_addr_q <= ret_addr_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    ins_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (fifo_clear),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.rom_addr  = fetch_pc_q;
    assign bus.rom_psen  = rom_psen;
    assign bus.ins_byte  = fifo_rdata.data;
    assign bus.ins_pc    = fifo_rdata.addr;
    assign bus.ins_valid = ~fifo_empty;
    assign bus.dbg_state = state_q;

endmodule
